// File: rtl/mac_vec_acc.sv
// Vector multiply-accumulate: a 4-deep pipeline (capture, lane products, lane sum, accumulate).
// Define MAC_VEC_SAT_EN to clamp the accumulator and report sticky saturation on out_sat.
`timescale 1ns/1ps

module mac_vec_acc #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic [LANES*DW-1:0]   in_weight,
    input  logic                  in_last,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_sat
);

    localparam int PW = 2*DW + 1;
    localparam int SW = PW + $clog2(LANES);

    logic stall;
    logic accept;
    logic commit;
    logic commit_last;

    logic                    s0_valid_q, s0_valid_d;
    logic                    s0_last_q, s0_last_d;
    logic [LANES*DW-1:0]     s0_data_q, s0_data_d;
    logic [LANES*DW-1:0]     s0_weight_q, s0_weight_d;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [PW-1:0]    s1_prod_q [LANES];
    logic signed [PW-1:0]    s1_prod_d [LANES];
    logic signed [PW-1:0]    lane_prod [LANES];

    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_last_q, s2_last_d;
    logic signed [SW-1:0]    s2_sum_q, s2_sum_d;
    logic signed [SW-1:0]    lane_sum;

    logic signed [ACC_W-1:0] s2_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_add;

    logic                    out_valid_q, out_valid_d;
    logic [ACC_W-1:0]        out_data_q, out_data_d;

    // Only a finished result waiting on a busy consumer can block the pipe.
    assign stall       = out_valid_q & ~out_ready & s2_valid_q & s2_last_q;
    assign in_ready    = reset & ~clear & ~stall;
    assign accept      = in_valid & in_ready;
    assign commit      = s2_valid_q & ~stall & ~clear;
    assign commit_last = commit & s2_last_q;

    // NOTE: combinational loops accumulate with blocking '='; each iteration must see the previous value.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_prod[i] = PW'($signed({1'b0, s0_data_q[i*DW +: DW]}))
                         * PW'($signed(s0_weight_q[i*DW +: DW]));
            lane_sum     = lane_sum + SW'(s1_prod_q[i]);
        end
    end

    assign s2_ext = ACC_W'(s2_sum_q);

`ifdef MAC_VEC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           sat_hit;

    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {s2_ext[ACC_W-1], s2_ext};
        sat_hit  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!sat_hit) begin
            acc_add = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            acc_add = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_add = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_add = acc_q + s2_ext;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_last_d   = s0_last_q;
        s0_data_d   = s0_data_q;
        s0_weight_d = s0_weight_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_sum_d    = s2_sum_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;

        if (clear) begin
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            acc_d      = '0;
        end else if (!stall) begin
            s0_valid_d = accept;
            if (accept) begin
                s0_last_d   = in_last;
                s0_data_d   = in_data;
                s0_weight_d = in_weight;
            end
            s1_valid_d = s0_valid_q;
            s1_last_d  = s0_last_q;
            s1_prod_d  = lane_prod;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_sum_d   = lane_sum;
        end

        if (commit) begin
            acc_d = commit_last ? '0 : acc_add;
        end
        if (commit_last) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_add;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: payload registers carry no reset; the stage valid bits decide whether they mean anything.
    always_ff @(posedge clk) begin
        s0_data_q   <= s0_data_d;
        s0_weight_q <= s0_weight_d;
        s1_prod_q   <= s1_prod_d;
        s2_sum_q    <= s2_sum_d;
    end

`ifdef MAC_VEC_SAT_EN
    logic sat_q, sat_d;
    logic out_sat_q, out_sat_d;

    always_comb begin
        sat_d     = sat_q;
        out_sat_d = out_sat_q;
        if (clear) begin
            sat_d = 1'b0;
        end else if (commit) begin
            sat_d = commit_last ? 1'b0 : (sat_q | sat_hit);
            if (commit_last) begin
                out_sat_d = sat_q | sat_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    assign out_sat = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
